router_output_arbiter: RTL

Output-port arbiter for the multi-core NoC router. It sits directly downstream of four single-entry input buffers (`buffer_router`) and directly upstream of the next-hop input buffer. Each cycle it selects one requesting input by round-robin, pops that buffer, and forwards the flit through a one-entry holding register to the downstream buffer. Multi-flit packets are never interleaved: a grant stays locked to one input until that input's tail flit has been forwarded.

---
 rtl/router_output_arbiter_if.sv | 24 ++
 rtl/router_output_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/router_output_arbiter_if.sv
// Handshake bundle between the four input buffers, the output arbiter and the
// next-hop buffer. master is the arbiter side; slave is the buffer/environment side.
interface router_output_arbiter_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic [3:0]             in_valid;
  logic [4*DATA_SIZE-1:0] in_data;
  logic [3:0]             in_re;
  logic                   out_we;
  logic [DATA_SIZE-1:0]   out_data;
  logic                   out_full;
  logic                   locked;
  logic [15:0]            flit_count;

  modport master (
    input  in_valid, in_data, out_full,
    output in_re, out_we, out_data, locked, flit_count
  );

  modport slave (
    output in_valid, in_data, out_full,
    input  in_re, out_we, out_data, locked, flit_count
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin output-port arbiter with packet locking and a one-entry holding
// register feeding the next-hop buffer.
module router_output_arbiter #(
  parameter int unsigned DATA_SIZE = 64
) (
  input logic                     clk,
  input logic                     reset,
  router_output_arbiter_if.master bus
);
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     src_q, src_d;
  logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic                 hold_v_q, hold_v_d;
  logic [CNT_W-1:0]     flit_count_q, flit_count_d;

  logic                 out_we_c;
  logic                 load_c;
  logic                 grant_valid_c;
  logic [PTR_W-1:0]     grant_c;
  logic [PTR_W-1:0]     idx_c;
  logic [3:0]           in_re_c;
  logic [DATA_SIZE-1:0] flit_c;

  // Grant: rotating scan from ptr in ARB, only the locked source in LOCKED.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_c       = ptr_q;
    idx_c         = '0;
    if (state_q == ARB) begin
      for (int k = 0; k < 4; k++) begin
        idx_c = ptr_q + PTR_W'(k);
        if (!grant_valid_c && bus.in_valid[idx_c]) begin
          grant_valid_c = 1'b1;
          grant_c       = idx_c;
        end
      end
    end else if (bus.in_valid[src_q]) begin
      grant_valid_c = 1'b1;
      grant_c       = src_q;
    end
  end

  // Next state, holding register and pop/write strobes.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    src_d        = src_q;
    hold_data_d  = hold_data_q;
    hold_v_d     = hold_v_q;
    flit_count_d = flit_count_q;

    out_we_c = hold_v_q & ~bus.out_full;
    load_c   = ~hold_v_q | out_we_c;
    flit_c   = bus.in_data[32'(grant_c) * DATA_SIZE +: DATA_SIZE];
    in_re_c  = (load_c && grant_valid_c) ? (4'b0001 << grant_c) : 4'b0000;

    if (out_we_c) begin
      flit_count_d = flit_count_q + CNT_W'(1);
      hold_v_d     = 1'b0;
    end

    // A capture on the draining edge replaces the entry, so no bubble.
    if (in_re_c != 4'b0000) begin
      hold_data_d = flit_c;
      hold_v_d    = 1'b1;
      if (flit_c[DATA_SIZE-1]) begin
        state_d = ARB;
        ptr_d   = grant_c + PTR_W'(1);
      end else begin
        state_d = LOCKED;
        src_d   = grant_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      src_q        <= '0;
      hold_data_q  <= '0;
      hold_v_q     <= 1'b0;
      flit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      src_q        <= src_d;
      hold_data_q  <= hold_data_d;
      hold_v_q     <= hold_v_d;
      flit_count_q <= flit_count_d;
    end
  end

  assign bus.in_re      = in_re_c;
  assign bus.out_we     = out_we_c;
  assign bus.out_data   = hold_data_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.flit_count = flit_count_q;

endmodule
